// File: rtl/hazard_match_gen_if.sv
// Hazard-unit side channel: Decode fields and hazard controls going in,
// match vector, qualified write flags and the stall counter coming out.
interface hazard_match_gen_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       RA1D;
    logic [3:0]       RA2D;
    logic [3:0]       WA3D;
    logic             RegWriteD;
    logic             MemtoRegD;
    logic             PCSrcD;
    logic             CondExE;
    logic             StallD;
    logic             FlushE;

    logic [4:0]       match;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             PCWrPendingF;
    logic             PCSrcW;
    logic [CNT_W-1:0] StallCnt;

    // The match generator itself.
    modport master (
        input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD,
        input  CondExE, StallD, FlushE,
        output match, RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF,
        output PCSrcW, StallCnt
    );

    // Pipeline / hazard unit side that feeds it and consumes its results.
    modport slave (
        output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, PCSrcD,
        output CondExE, StallD, FlushE,
        input  match, RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF,
        input  PCSrcW, StallCnt
    );
endinterface

// File: rtl/hazard_match_gen.sv
// Producer side of the hazard unit: carries register addresses and control
// bits through E/M/W, produces the unqualified address-match vector and the
// qualified write flags, and counts load-use stall cycles (saturating).
module hazard_match_gen #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    hazard_match_gen_if.master hz
);

    // Execute stage
    logic [3:0]       ra1E, ra2E, wa3E;
    logic             regWriteE, memtoRegE, pcSrcE;
    // Memory stage (the load flag stops at E: nothing downstream consumes it)
    logic [3:0]       wa3M;
    logic             regWriteM, pcSrcM;
    // Writeback stage
    logic [3:0]       wa3W;
    logic             regWriteW, pcSrcW;
    // Performance counter
    logic [CNT_W-1:0] stallCnt;
    // Combinational results
    logic [4:0]       matchVec;

    // D->E register: a flush turns the slot into an all-zero bubble.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values no matter how the statements are ordered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra1E      <= '0;
            ra2E      <= '0;
            wa3E      <= '0;
            regWriteE <= 1'b0;
            memtoRegE <= 1'b0;
            pcSrcE    <= 1'b0;
        end else if (hz.FlushE) begin
            ra1E      <= '0;
            ra2E      <= '0;
            wa3E      <= '0;
            regWriteE <= 1'b0;
            memtoRegE <= 1'b0;
            pcSrcE    <= 1'b0;
        end else begin
            ra1E      <= hz.RA1D;
            ra2E      <= hz.RA2D;
            wa3E      <= hz.WA3D;
            regWriteE <= hz.RegWriteD;
            memtoRegE <= hz.MemtoRegD;
            pcSrcE    <= hz.PCSrcD;
        end
    end

    // E->M and M->W registers: controls are qualified by the condition check
    // as they leave Execute; no stall or flush applies to these stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wa3M      <= '0;
            regWriteM <= 1'b0;
            pcSrcM    <= 1'b0;
            wa3W      <= '0;
            regWriteW <= 1'b0;
            pcSrcW    <= 1'b0;
        end else begin
            wa3M      <= wa3E;
            regWriteM <= regWriteE & hz.CondExE;
            pcSrcM    <= pcSrcE & hz.CondExE;
            wa3W      <= wa3M;
            regWriteW <= regWriteM;
            pcSrcW    <= pcSrcM;
        end
    end

    // Stall-cycle counter: counts edges with StallD high, holds at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
        end else if (hz.StallD && (stallCnt != '1)) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    // Unqualified address compares; the hazard unit applies the write flags.
    // NOTE: assign a default first so every path drives the signal and no
    // latch is inferred.
    always_comb begin
        matchVec    = '0;
        matchVec[4] = (ra1E == wa3M);
        matchVec[3] = (ra2E == wa3M);
        matchVec[2] = (ra1E == wa3W);
        matchVec[1] = (ra2E == wa3W);
        matchVec[0] = (hz.RA1D == wa3E) | (hz.RA2D == wa3E);
    end

    assign hz.match        = matchVec;
    assign hz.RegWriteM    = regWriteM;
    assign hz.RegWriteW    = regWriteW;
    assign hz.MemtoRegE    = memtoRegE;
    // Execute's PC-write flag is taken before the condition check: a
    // conservative pending indication is harmless, a missed one is not.
    assign hz.PCWrPendingF = hz.PCSrcD | pcSrcE | pcSrcM;
    assign hz.PCSrcW       = pcSrcW;
    assign hz.StallCnt     = stallCnt;

endmodule
